// File: rtl/vga_timing_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_pkg
//  Description : Shared 640x480@60 raster constants and coordinate helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_gen_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned COORD_W   = 10;
    localparam int unsigned COORD_MAX = 1024;

    typedef logic [COORD_W-1:0] coord_t;

    // True when n lies in the half-open range [lo, lo+len).
    function automatic logic in_window(coord_t n, int unsigned lo, int unsigned len);
        return (32'(n) >= lo) && (32'(n) < lo + len);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen_if
//  Description : Raster coordinates, strobes and DAC pins of the timing source.
//  Revision    : 1.0 - initial release
// ============================================================================
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    coord_t x;
    coord_t y;
    logic   active_pixels;
    logic   VGA_HS;
    logic   VGA_VS;
    logic   VGA_BLANK_N;
    logic   VGA_SYNC_N;
    logic   VGA_CLK;
    logic   pix_en;
    logic   frame_start;
    logic   vblank_start;

    modport master (
        output x, y, active_pixels, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output VGA_CLK, pix_en, frame_start, vblank_start
    );

    modport slave (
        input x, y, active_pixels, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input VGA_CLK, pix_en, frame_start, vblank_start
    );

endinterface
`default_nettype wire

// File: rtl/vga_pix_div.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pix_div
//  Description : System-clock divider producing the pixel tick and DAC clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_pix_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      pix_en,
    output logic      vga_clk
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pix_en_q,  pix_en_d;
    logic             vga_clk_q, vga_clk_d;

    if (CLK_DIV == 0) begin : g_bad_div
        $error("vga_pix_div: CLK_DIV must be at least 1");
    end

    if (CLK_DIV == 1) begin : g_div1
        // Every clock is a pixel; there is no sub-pixel phase to toggle the DAC clock.
        always_comb begin
            div_cnt_d = div_cnt_q;
            pix_en_d  = 1'b1;
            vga_clk_d = 1'b1;
        end
    end else begin : g_divn
        // Flags decode the next count so they line up with div_cnt.
        always_comb begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
            pix_en_d  = (div_cnt_d == DIV_LAST);
            vga_clk_d = (div_cnt_d >= DIV_HALF);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            pix_en_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            pix_en_q  <= pix_en_d;
            vga_clk_q <= vga_clk_d;
        end
    end

    assign pix_en  = pix_en_q;
    assign vga_clk = vga_clk_q;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : VGA raster scanner: x/y counters, sync/blank decode, strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    vga_timing_gen_if.master vga
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam coord_t      X_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t      Y_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t      Y_VBLANK = coord_t'(V_ACTIVE);

    if (H_TOTAL > COORD_MAX) begin : g_bad_htotal
        $error("vga_timing_gen: H_TOTAL exceeds the 10-bit counter range");
    end
    if (V_TOTAL > COORD_MAX) begin : g_bad_vtotal
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit counter range");
    end

    logic   pix_en;
    logic   vga_clk;

    coord_t x_q, x_d;
    coord_t y_q, y_d;
    logic   active_q,       active_d;
    logic   hs_q,           hs_d;
    logic   vs_q,           vs_d;
    logic   frame_start_q,  frame_start_d;
    logic   vblank_start_q, vblank_start_d;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .pix_en  (pix_en),
        .vga_clk (vga_clk)
    );

    // Decode from the next-state coordinates so every output changes with x/y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_en) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        active_d       = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
        hs_d           = !in_window(x_d, HS_START, H_SYNC);
        vs_d           = !in_window(y_d, VS_START, V_SYNC);
        frame_start_d  = pix_en && (x_d == '0) && (y_d == '0);
        vblank_start_d = pix_en && (x_d == '0) && (y_d == Y_VBLANK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q            <= X_LAST;
            y_q            <= Y_LAST;
            active_q       <= 1'b0;
            hs_q           <= 1'b1;
            vs_q           <= 1'b1;
            frame_start_q  <= 1'b0;
            vblank_start_q <= 1'b0;
        end else begin
            x_q            <= x_d;
            y_q            <= y_d;
            active_q       <= active_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            frame_start_q  <= frame_start_d;
            vblank_start_q <= vblank_start_d;
        end
    end

    assign vga.x             = x_q;
    assign vga.y             = y_q;
    assign vga.active_pixels = active_q;
    assign vga.VGA_HS        = hs_q;
    assign vga.VGA_VS        = vs_q;
    assign vga.VGA_BLANK_N   = active_q;
    assign vga.VGA_SYNC_N    = 1'b0;
    assign vga.VGA_CLK       = vga_clk;
    assign vga.pix_en        = pix_en;
    assign vga.frame_start   = frame_start_q;
    assign vga.vblank_start  = vblank_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Three scanners (full VGA /2, tiny /1, tiny /3) vs arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int NDUT = 3;
    localparam int P_D  [NDUT] = '{2, 1, 3};
    localparam int P_HA [NDUT] = '{640, 8, 10};
    localparam int P_HF [NDUT] = '{16, 2, 1};
    localparam int P_HS [NDUT] = '{96, 3, 2};
    localparam int P_HB [NDUT] = '{48, 2, 3};
    localparam int P_VA [NDUT] = '{480, 6, 5};
    localparam int P_VF [NDUT] = '{10, 1, 2};
    localparam int P_VS [NDUT] = '{2, 2, 1};
    localparam int P_VB [NDUT] = '{33, 2, 1};

    typedef struct {
        int x, y;
        bit act, hs, vs, pe, vck, fs, vb;
    } exp_t;

    logic            clk;
    logic [NDUT-1:0] rst_n;
    logic [28:0]     ov [NDUT];
    int              k  [NDUT];
    int              total = 0;
    int              bad   = 0;
    int              cur_dut;
    bit              did_mid;

    vga_timing_gen_if if_a ();
    vga_timing_gen_if if_b ();
    vga_timing_gen_if if_c ();

    vga_timing_gen #(.CLK_DIV(2)) u_a (.clk(clk), .rst_n(rst_n[0]), .vga(if_a));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_b (.clk(clk), .rst_n(rst_n[1]), .vga(if_b));

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(3),
        .V_ACTIVE(5), .V_FP(2), .V_SYNC(1), .V_BP(1)
    ) u_c (.clk(clk), .rst_n(rst_n[2]), .vga(if_c));

    assign ov[0] = {if_a.x, if_a.y, if_a.active_pixels, if_a.VGA_HS, if_a.VGA_VS,
                    if_a.VGA_BLANK_N, if_a.VGA_SYNC_N, if_a.VGA_CLK, if_a.pix_en,
                    if_a.frame_start, if_a.vblank_start};
    assign ov[1] = {if_b.x, if_b.y, if_b.active_pixels, if_b.VGA_HS, if_b.VGA_VS,
                    if_b.VGA_BLANK_N, if_b.VGA_SYNC_N, if_b.VGA_CLK, if_b.pix_en,
                    if_b.frame_start, if_b.vblank_start};
    assign ov[2] = {if_c.x, if_c.y, if_c.active_pixels, if_c.VGA_HS, if_c.VGA_VS,
                    if_c.VGA_BLANK_N, if_c.VGA_SYNC_N, if_c.VGA_CLK, if_c.pix_en,
                    if_c.frame_start, if_c.vblank_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s dut=%0d k=%0d t=%0t observed=%0d expected=%0d",
                     tag, cur_dut, k[cur_dut], $time, obs, exp);
        end
    endtask

    // Pixel ticks taken after k clock edges since reset release.
    function automatic int ticks(int i, int kk);
        if (kk <= 0) return 0;
        if (P_D[i] == 1) return kk - 1;
        return kk / P_D[i];
    endfunction

    function automatic exp_t model(int i, int kk);
        exp_t e;
        int ht, vt, t, p;
        ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
        vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
        t  = ticks(i, kk);
        p  = (t == 0) ? -1 : (t - 1) % (ht * vt);
        e.x   = (t == 0) ? ht - 1 : p % ht;
        e.y   = (t == 0) ? vt - 1 : p / ht;
        e.act = (e.x < P_HA[i]) && (e.y < P_VA[i]);
        e.hs  = !((e.x >= P_HA[i] + P_HF[i]) && (e.x < P_HA[i] + P_HF[i] + P_HS[i]));
        e.vs  = !((e.y >= P_VA[i] + P_VF[i]) && (e.y < P_VA[i] + P_VF[i] + P_VS[i]));
        e.pe  = (kk >= 1) && ((P_D[i] == 1) || (kk % P_D[i] == P_D[i] - 1));
        e.vck = (kk >= 1) && ((P_D[i] == 1) || (kk % P_D[i] >= P_D[i] / 2));
        e.fs  = (kk >= 1) && (t > ticks(i, kk - 1)) && (p == 0);
        e.vb  = (kk >= 1) && (t > ticks(i, kk - 1)) && (p == P_VA[i] * ht);
        return e;
    endfunction

    task automatic check_all(input int i);
        exp_t        e;
        logic [28:0] o;
        e = model(i, k[i]);
        o = ov[i];
        cur_dut = i;
        check_eq("x",            int'(o[28:19]), e.x);
        check_eq("y",            int'(o[18:9]),  e.y);
        check_eq("active",       int'(o[8]),     int'(e.act));
        check_eq("hs",           int'(o[7]),     int'(e.hs));
        check_eq("vs",           int'(o[6]),     int'(e.vs));
        check_eq("blank_n",      int'(o[5]),     int'(e.act));
        check_eq("sync_n",       int'(o[4]),     0);
        check_eq("vga_clk",      int'(o[3]),     int'(e.vck));
        check_eq("pix_en",       int'(o[2]),     int'(e.pe));
        check_eq("frame_start",  int'(o[1]),     int'(e.fs));
        check_eq("vblank_start", int'(o[0]),     int'(e.vb));
    endtask

    initial begin
        rst_n   = '0;
        did_mid = 1'b0;
        for (int i = 0; i < NDUT; i++) k[i] = 0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) check_all(i);
        rst_n = '1;

        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            for (int i = 0; i < NDUT; i++) if (rst_n[i]) k[i]++;
            #1;
            // Full-size scanner: reset mid-hsync at x=700 on the first line.
            if (!did_mid && rst_n[0] && k[0] == 1402) begin
                cur_dut = 0;
                check_eq("hs_before_rst", int'(ov[0][7]), 0);
                rst_n[0] = 1'b0;
                #1;
                k[0]    = 0;
                did_mid = 1'b1;
                check_all(0);
            end
            for (int i = 1; i < NDUT; i++) begin
                if (rst_n[i] && $urandom_range(0, 999) == 0) begin
                    rst_n[i] = 1'b0;
                    #1;
                    k[i] = 0;
                    check_all(i);
                end
            end
            @(negedge clk);
            for (int i = 0; i < NDUT; i++) check_all(i);
            for (int i = 0; i < NDUT; i++)
                if (!rst_n[i] && $urandom_range(0, 3) == 0) rst_n[i] = 1'b1;
        end

        cur_dut = 0;
        check_eq("mid_line_reset_hit", int'(did_mid), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
